// File: rtl/vga_timing_pkg.sv
// Shared types and default 1024x768 timing for the VGA scanout path.
package vga_timing_pkg;

  typedef enum logic [1:0] {
    PHASE_ACTIVE,
    PHASE_FRONT,
    PHASE_SYNC,
    PHASE_BACK
  } phase_t;

  typedef enum logic [1:0] {
    STATE_IDLE,
    STATE_RUN,
    STATE_DRAIN
  } ctrl_state_t;

  localparam int unsigned DEFAULT_H_ACTIVE = 1024;
  localparam int unsigned DEFAULT_H_FRONT  = 24;
  localparam int unsigned DEFAULT_H_SYNC   = 136;
  localparam int unsigned DEFAULT_H_BACK   = 144;
  localparam int unsigned DEFAULT_V_ACTIVE = 768;
  localparam int unsigned DEFAULT_V_FRONT  = 3;
  localparam int unsigned DEFAULT_V_SYNC   = 6;
  localparam int unsigned DEFAULT_V_BACK   = 29;
  localparam bit          DEFAULT_SYNC_ACTIVE_LOW = 1'b1;
  localparam int unsigned DEFAULT_COUNTER_SIZE    = 11;

  function automatic int unsigned axis_total(input int unsigned active, input int unsigned front,
                                             input int unsigned sync, input int unsigned back);
    return active + front + sync + back;
  endfunction

endpackage

// File: rtl/vga_timing_axis.sv
// One scan axis: position counter with explicit wrap, plus phase decode for sync/active.
module vga_timing_axis
  import vga_timing_pkg::*;
#(
  parameter int unsigned ACTIVE       = DEFAULT_H_ACTIVE,
  parameter int unsigned FRONT        = DEFAULT_H_FRONT,
  parameter int unsigned SYNC         = DEFAULT_H_SYNC,
  parameter int unsigned BACK         = DEFAULT_H_BACK,
  parameter int unsigned COUNTER_SIZE = DEFAULT_COUNTER_SIZE
) (
  input  logic                    control_clock,
  input  logic                    reset,
  input  logic                    clear,
  input  logic                    advance,
  output logic [COUNTER_SIZE-1:0] count,
  output logic                    wrap,
  output logic                    sync_active,
  output logic                    active
);

  localparam int unsigned TOTAL = axis_total(ACTIVE, FRONT, SYNC, BACK);
  localparam logic [COUNTER_SIZE-1:0] LAST        = COUNTER_SIZE'(TOTAL - 1);
  localparam logic [COUNTER_SIZE-1:0] FRONT_START = COUNTER_SIZE'(ACTIVE);
  localparam logic [COUNTER_SIZE-1:0] SYNC_START  = COUNTER_SIZE'(ACTIVE + FRONT);
  localparam logic [COUNTER_SIZE-1:0] BACK_START  = COUNTER_SIZE'(ACTIVE + FRONT + SYNC);

  phase_t phase;

  always_ff @(posedge control_clock) begin
    if (reset || clear) begin
      count <= '0;
    end else if (advance) begin
      count <= (count == LAST) ? '0 : count + 1'b1;
    end
  end

  always_comb begin
    wrap = advance && (count == LAST);
    if (count < FRONT_START) begin
      phase = PHASE_ACTIVE;
    end else if (count < SYNC_START) begin
      phase = PHASE_FRONT;
    end else if (count < BACK_START) begin
      phase = PHASE_SYNC;
    end else begin
      phase = PHASE_BACK;
    end
    sync_active = (phase == PHASE_SYNC);
    active      = (phase == PHASE_ACTIVE);
  end

endmodule

// File: rtl/vga_timing_sequencer.sv
// VGA scanout sequencer: IDLE/RUN/DRAIN control over two axis counters with
// registered sync, blanking, position and strobe outputs.
module vga_timing_sequencer
  import vga_timing_pkg::*;
#(
  parameter int unsigned H_ACTIVE        = DEFAULT_H_ACTIVE,
  parameter int unsigned H_FRONT         = DEFAULT_H_FRONT,
  parameter int unsigned H_SYNC          = DEFAULT_H_SYNC,
  parameter int unsigned H_BACK          = DEFAULT_H_BACK,
  parameter int unsigned V_ACTIVE        = DEFAULT_V_ACTIVE,
  parameter int unsigned V_FRONT         = DEFAULT_V_FRONT,
  parameter int unsigned V_SYNC          = DEFAULT_V_SYNC,
  parameter int unsigned V_BACK          = DEFAULT_V_BACK,
  parameter bit          SYNC_ACTIVE_LOW = DEFAULT_SYNC_ACTIVE_LOW,
  parameter int unsigned COUNTER_SIZE    = DEFAULT_COUNTER_SIZE
) (
  input  logic                    control_clock,
  input  logic                    reset,
  input  logic                    pixel_enable,
  input  logic                    run,
  output logic                    h_sync,
  output logic                    v_sync,
  output logic                    display_enable,
  output logic [COUNTER_SIZE-1:0] x_position,
  output logic [COUNTER_SIZE-1:0] y_position,
  output logic                    line_start,
  output logic                    frame_start,
  output logic                    running
);

  localparam logic SYNC_IDLE   = SYNC_ACTIVE_LOW;
  localparam logic SYNC_ASSERT = ~SYNC_ACTIVE_LOW;

  ctrl_state_t state, state_next;
  logic tick, going_idle, counters_clear;
  logic h_wrap, v_wrap, h_sync_active, v_sync_active, h_active, v_active;
  logic [COUNTER_SIZE-1:0] h_count, v_count;

  always_ff @(posedge control_clock) begin
    if (reset) begin
      state <= STATE_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // v_wrap is only high on the tick presenting the final pixel of the frame
  always_comb begin
    state_next = state;
    case (state)
      STATE_IDLE:  if (run) state_next = STATE_RUN;
      STATE_RUN:   if (!run) state_next = STATE_DRAIN;
      STATE_DRAIN: begin
        if (run) begin
          state_next = STATE_RUN;
        end else if (v_wrap) begin
          state_next = STATE_IDLE;
        end
      end
      default:     state_next = STATE_IDLE;
    endcase
  end

  always_comb begin
    running        = (state != STATE_IDLE);
    tick           = pixel_enable && running;
    counters_clear = (state == STATE_IDLE);
    going_idle     = running && (state_next == STATE_IDLE);
  end

  vga_timing_axis #(
    .ACTIVE(H_ACTIVE), .FRONT(H_FRONT), .SYNC(H_SYNC), .BACK(H_BACK),
    .COUNTER_SIZE(COUNTER_SIZE)
  ) u_h_axis (
    .control_clock(control_clock),
    .reset        (reset),
    .clear        (counters_clear),
    .advance      (tick),
    .count        (h_count),
    .wrap         (h_wrap),
    .sync_active  (h_sync_active),
    .active       (h_active)
  );

  vga_timing_axis #(
    .ACTIVE(V_ACTIVE), .FRONT(V_FRONT), .SYNC(V_SYNC), .BACK(V_BACK),
    .COUNTER_SIZE(COUNTER_SIZE)
  ) u_v_axis (
    .control_clock(control_clock),
    .reset        (reset),
    .clear        (counters_clear),
    .advance      (h_wrap),
    .count        (v_count),
    .wrap         (v_wrap),
    .sync_active  (v_sync_active),
    .active       (v_active)
  );

  // Presentation registers; strobes default low so they never stretch across idle cycles
  always_ff @(posedge control_clock) begin
    if (reset || going_idle) begin
      h_sync         <= SYNC_IDLE;
      v_sync         <= SYNC_IDLE;
      display_enable <= 1'b0;
      x_position     <= '0;
      y_position     <= '0;
      line_start     <= 1'b0;
      frame_start    <= 1'b0;
    end else begin
      line_start  <= tick && (h_count == '0);
      frame_start <= tick && (h_count == '0) && (v_count == '0);
      if (tick) begin
        x_position     <= h_count;
        y_position     <= v_count;
        display_enable <= h_active && v_active;
        h_sync         <= h_sync_active ? SYNC_ASSERT : SYNC_IDLE;
        v_sync         <= v_sync_active ? SYNC_ASSERT : SYNC_IDLE;
      end
    end
  end

endmodule

// File: doc/vga_timing_sequencer.md
# vga_timing_sequencer

Sequences the horizontal and vertical pixel counters of the VGA output path and produces the sync, blanking and position signals for the pixel generator. Owns start/stop of scanout: a frame starts only at position (0,0) and a stop request always lets the current frame finish. Sits between the pixel-clock-enable source and the frame-buffer read / colour output stage.

## Interface
- H_ACTIVE, 1024, visible pixels per line
- H_FRONT, 24, horizontal front porch (pixels)
- H_SYNC, 136, horizontal sync width (pixels)
- H_BACK, 144, horizontal back porch (pixels); H_TOTAL = sum = 1328
- V_ACTIVE, 768, visible lines per frame
- V_FRONT, 3, vertical front porch (lines)
- V_SYNC, 6, vertical sync width (lines)
- V_BACK, 29, vertical back porch (lines); V_TOTAL = sum = 806
- SYNC_ACTIVE_LOW, 1, 1 = h_sync/v_sync asserted low
- COUNTER_SIZE, 11, width of counters and positions; H_TOTAL and V_TOTAL must be ≤ 2^COUNTER_SIZE
- control_clock  in  1  single clock, all logic on rising edge
- reset  in  1  synchronous, active-high
- pixel_enable  in  1  one-cycle tick per pixel period
- run  in  1  level; 1 = scan out, 0 = stop at end of frame
- h_sync  out  1  horizontal sync, polarity per SYNC_ACTIVE_LOW
- v_sync  out  1  vertical sync, polarity per SYNC_ACTIVE_LOW
- display_enable  out  1  1 while presented pixel is in the active area
- x_position  out  COUNTER_SIZE  horizontal position of presented pixel
- y_position  out  COUNTER_SIZE  vertical position of presented pixel
- line_start  out  1  one-cycle pulse, presented x = 0
- frame_start  out  1  one-cycle pulse, presented (x,y) = (0,0)
- running  out  1  1 in RUN or DRAIN

## Operation
- Control FSM: IDLE, RUN, DRAIN.
  - IDLE: counters held at 0; syncs inactive; display_enable 0; no strobes. run=1 → RUN on next edge.
  - RUN: on each pixel_enable tick, present (h_count, v_count), then advance. run=0 → DRAIN.
  - DRAIN: same as RUN; run=1 → back to RUN without interruption. On the tick presenting (H_TOTAL-1, V_TOTAL-1) → IDLE, counters 0.
- Advance: h_count increments; at H_TOTAL-1 it wraps to 0 and v_count increments; v_count wraps at V_TOTAL-1 to 0.
- Presentation registers load only on ticks in RUN/DRAIN:
  - x/y = counters;
  - display_enable = (h < H_ACTIVE) && (v < V_ACTIVE);
  - h_sync active for h in [H_ACTIVE+H_FRONT, H_ACTIVE+H_FRONT+H_SYNC-1];
  - v_sync likewise on v.
- line_start and frame_start are high only on the cycle following the presenting tick, and are 0 on all other cycles, including non-tick cycles.
- Transition to IDLE forces outputs to reset values on the same edge.
- Counter arithmetic is unsigned COUNTER_SIZE bits; wraps are explicit compares and never rely on overflow.

## Timing
- Reset values: h_sync = v_sync = SYNC_ACTIVE_LOW (inactive); display_enable 0; x_position/y_position 0; line_start, frame_start, running 0; state IDLE.
- Reset mid-frame: all of the above on the next edge, regardless of pixel_enable.
- Latency: outputs update one control_clock after the pixel_enable tick that presents the pixel.
- First frame: run sampled high in IDLE → RUN at edge N. The first tick after edge N presents (0,0) and produces frame_start.
- pixel_enable high on consecutive cycles is legal; each cycle is one pixel.
- pixel_enable with the FSM in IDLE is ignored.
- run toggling 1→0→1 within one frame causes no gap and no extra frame_start.

## Structure
- Shared package vga_timing_pkg holds:
  - the phase enum ACTIVE/FRONT/SYNC/BACK;
  - the control state enum;
  - the default 1024×768 timing constants.
- One sub-module, vga_timing_axis, instantiated once per axis. It contains:
  - a counter with `advance` input and `wrap` output;
  - the phase decode for that axis;
  - the sync and active outputs for that axis.
- The horizontal `wrap` drives the vertical `advance`.

## Test plan
- Reset then run=1, pixel_enable every cycle → frame_start after first tick with x=y=0; h_sync low for x 1048..1183; line_start every 1328 ticks.
- Full frame → v_sync low for y 771..776; display_enable low for y ≥ 768; frame_start period 1328×806 ticks.
- pixel_enable every 3rd cycle → outputs change only after ticks; strobes are one cycle wide.
- run=0 at y=400 → running stays 1 until the tick at (1327,805), then outputs return to reset values; no further strobes.
- run=0 then run=1 within the same frame → no stop, single frame_start per frame.
- reset at (500,300) → all outputs at reset values next cycle; with run held 1, frame restarts at (0,0).
